// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision divider.
package fp_pkg;

    localparam int          FP_EXP_W  = 8;
    localparam int          FP_FRAC_W = 23;
    localparam int          FP_BIAS   = 127;
    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fsm_state_e;

    // Operand classes; denormals are folded into ZERO
    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    // Classify an operand from its exponent and fraction fields.
    function automatic fp_class_e fp_classify(
        input logic [FP_EXP_W-1:0]  exp_bits,
        input logic [FP_FRAC_W-1:0] frac_bits
    );
        fp_class_e cls;
        if (exp_bits == {FP_EXP_W{1'b0}}) begin
            cls = ZERO;
        end else if (exp_bits == {FP_EXP_W{1'b1}}) begin
            cls = (frac_bits == {FP_FRAC_W{1'b0}}) ? INF : NAN;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single word into sign, exponent, mantissa with the
// hidden bit set, and an operand class.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [FP_EXP_W+FP_FRAC_W:0] word_i,
    output logic                        sign_o,
    output logic [FP_EXP_W-1:0]         exp_o,
    output logic [FP_FRAC_W:0]          mant_o,
    output fp_class_e                   class_o
);

    assign sign_o  = word_i[FP_EXP_W+FP_FRAC_W];
    assign exp_o   = word_i[FP_EXP_W+FP_FRAC_W-1:FP_FRAC_W];
    // The hidden bit is always set; zero/denormal handling goes through class_o.
    assign mant_o  = {1'b1, word_i[FP_FRAC_W-1:0]};
    assign class_o = fp_classify(word_i[FP_EXP_W+FP_FRAC_W-1:FP_FRAC_W],
                                 word_i[FP_FRAC_W-1:0]);

endmodule

// File: rtl/floatingpoint_divider.sv
// Multi-cycle IEEE-754 single-precision divider: restoring mantissa division
// (25 quotient bits, one per cycle), one normalisation step, truncation.
// Optional macro FPDIV_SPECIAL_EN adds NaN/inf/zero handling, denormal flush
// and exponent saturation; without it the exponent simply wraps to 8 bits.
module floatingpoint_divider
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] dataA_i,
    input  logic [DATA_WIDTH-1:0] dataB_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int MANT_W = FP_FRAC_W + 1;   // mantissa with hidden bit
    localparam int REM_W  = MANT_W + 2;      // partial remainder
    localparam int Q_W    = MANT_W + 1;      // quotient bits produced
    localparam logic signed [9:0] EXP_OFS_HI = 10'(FP_BIAS);
    localparam logic signed [9:0] EXP_OFS_LO = 10'(FP_BIAS - 1);

    // Unpacked operands
    logic                sign_a_s, sign_b_s;
    logic [FP_EXP_W-1:0] exp_a_s, exp_b_s;
    logic [MANT_W-1:0]   mant_a_s, mant_b_s;
    fp_class_e           class_a_s, class_b_s;

    fp_unpack u_unpack_a (
        .word_i  (dataA_i),
        .sign_o  (sign_a_s),
        .exp_o   (exp_a_s),
        .mant_o  (mant_a_s),
        .class_o (class_a_s)
    );

    fp_unpack u_unpack_b (
        .word_i  (dataB_i),
        .sign_o  (sign_b_s),
        .exp_o   (exp_b_s),
        .mant_o  (mant_b_s),
        .class_o (class_b_s)
    );

    // State
    fsm_state_e             state_q;
    logic                   ready_q;
    logic                   valid_q;
    logic                   sign_q;
    logic signed [9:0]      exp_q;
    logic [REM_W-1:0]       rem_q;
    logic [MANT_W-1:0]      div_q;
    logic [Q_W-1:0]         q_q;
    logic [4:0]             cnt_q;
    logic [DATA_WIDTH-1:0]  data_q;
`ifdef FPDIV_SPECIAL_EN
    fp_class_e              class_a_q;
    fp_class_e              class_b_q;
`endif

    // Next-state values
    logic                   rem_ge_s;
    logic [REM_W-1:0]       rem_sub_s;
    logic [REM_W-1:0]       rem_d;
    logic [Q_W-1:0]         q_d;
    logic signed [9:0]      exp_calc_s;
    logic [FP_FRAC_W-1:0]   frac_s;
    logic [DATA_WIDTH-1:0]  result_d;
    logic                   unused_s;

    // One restoring-division step: subtract if it fits, then shift.
    always_comb begin
        rem_ge_s  = 1'b0;
        rem_sub_s = '0;
        rem_ge_s  = (rem_q >= {2'b00, div_q});
        if (rem_ge_s) begin
            rem_sub_s = rem_q - {2'b00, div_q};
        end else begin
            rem_sub_s = rem_q;
        end
        rem_d = {rem_sub_s[REM_W-2:0], 1'b0};
        q_d   = {q_q[Q_W-2:0], rem_ge_s};
    end

    // Normalise the quotient, build the exponent and pack the result word.
    always_comb begin
        exp_calc_s = '0;
        frac_s     = '0;
        if (q_q[Q_W-1]) begin
            exp_calc_s = exp_q + EXP_OFS_HI;
            frac_s     = q_q[Q_W-2:1];
        end else begin
            exp_calc_s = exp_q + EXP_OFS_LO;
            frac_s     = q_q[Q_W-3:0];
        end
        result_d = {sign_q, exp_calc_s[FP_EXP_W-1:0], frac_s};
`ifdef FPDIV_SPECIAL_EN
        if ((class_a_q == NAN) || (class_b_q == NAN) ||
            ((class_a_q == ZERO) && (class_b_q == ZERO)) ||
            ((class_a_q == INF) && (class_b_q == INF))) begin
            result_d = FP_QNAN;
        end else if ((class_b_q == ZERO) || (class_a_q == INF)) begin
            result_d = {sign_q, 8'hFF, 23'd0};
        end else if ((class_a_q == ZERO) || (class_b_q == INF)) begin
            result_d = {sign_q, 31'd0};
        end else if (exp_calc_s >= 10'sd255) begin
            result_d = {sign_q, 8'hFF, 23'd0};
        end else if (exp_calc_s <= 10'sd0) begin
            result_d = {sign_q, 31'd0};
        end else begin
            result_d = {sign_q, exp_calc_s[FP_EXP_W-1:0], frac_s};
        end
`endif
    end

    // The remainder MSB never survives the shift; in the plain build the
    // class outputs and upper exponent bits have no consumer either.
`ifdef FPDIV_SPECIAL_EN
    assign unused_s = rem_sub_s[REM_W-1];
`else
    assign unused_s = ^{rem_sub_s[REM_W-1], exp_calc_s[9:8], class_a_s, class_b_s};
`endif

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            q_q       <= '0;
            cnt_q     <= 5'd0;
            data_q    <= '0;
`ifdef FPDIV_SPECIAL_EN
            class_a_q <= ZERO;
            class_b_q <= ZERO;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        sign_q    <= sign_a_s ^ sign_b_s;
                        exp_q     <= $signed({2'b00, exp_a_s}) - $signed({2'b00, exp_b_s});
                        rem_q     <= {2'b00, mant_a_s};
                        div_q     <= mant_b_s;
                        q_q       <= '0;
                        cnt_q     <= 5'd24;
`ifdef FPDIV_SPECIAL_EN
                        class_a_q <= class_a_s;
                        class_b_q <= class_b_s;
`endif
                        ready_q   <= 1'b0;
                        state_q   <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    if (cnt_q == 5'd0) begin
                        state_q <= NORM;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                NORM: begin
                    data_q  <= result_d;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_floatingpoint_divider.sv
// Randomised and directed bench for floatingpoint_divider against a
// behavioural quotient model and an operation timeline.
module tb_floatingpoint_divider;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [31:0] dataA_i = 32'd0;
    logic [31:0] dataB_i = 32'd0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    floatingpoint_divider #(.DATA_WIDTH(32)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .dataA_i (dataA_i),
        .dataB_i (dataB_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected quotient word computed with plain integer arithmetic.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q;
        int              e;
        logic            s;
        logic [22:0]     f;
        logic [31:0]     r;
`ifdef FPDIV_SPECIAL_EN
        bit za, zb, ia, ib, na, nb;
`endif
        s  = a[31] ^ b[31];
        ma = 64'd8388608 + 64'(a[22:0]);
        mb = 64'd8388608 + 64'(b[22:0]);
        q  = (ma * 64'd16777216) / mb;
        if (q >= 64'd16777216) begin
            f = 23'(q / 64'd2);
            e = int'(a[30:23]) - int'(b[30:23]) + 127;
        end else begin
            f = 23'(q);
            e = int'(a[30:23]) - int'(b[30:23]) + 126;
        end
        r = {s, e[7:0], f};
`ifdef FPDIV_SPECIAL_EN
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (na || nb || (za && zb) || (ia && ib)) r = 32'h7FC00000;
        else if (zb || ia)                        r = {s, 8'hFF, 23'd0};
        else if (za || ib)                        r = {s, 31'd0};
        else if (e >= 255)                        r = {s, 8'hFF, 23'd0};
        else if (e <= 0)                          r = {s, 31'd0};
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference timeline: idle, or an operation N edges past its accept.
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    logic [31:0] m_cur  = 32'd0;
    logic [31:0] m_last = 32'd0;

    // Advance the reference timeline on every clock edge / reset.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_last <= 32'd0;
        end else if (!m_busy) begin
            if (valid_i) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_cur  <= fp_model(dataA_i, dataB_i);
            end
        end else if (m_age < 26) begin
            m_age <= m_age + 1;
            if (m_age == 25) m_last <= m_cur;
        end else if (ready_i) begin
            m_busy <= 1'b0;
        end
    end

    // Compare every DUT output against the timeline once per cycle.
    always @(negedge clk_i) begin
        if (check_en) begin
            check("ready_o", {31'd0, ready_o}, {31'd0, !m_busy});
            check("valid_o", {31'd0, valid_o}, {31'd0, (m_busy && (m_age == 26))});
            check("data_o",  data_o, m_last);
        end
    end

    // Issue one operation from a negedge; returns result and accept-to-valid edges.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          input bit junk, output logic [31:0] res, output int lat);
        int w;
        w = 0;
        while (ready_o !== 1'b1 && w < 64) begin
            @(negedge clk_i);
            w++;
        end
        check("accept_ready", {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        dataA_i = a;
        dataB_i = b;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        dataA_i = $urandom;
        dataB_i = $urandom;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 64) begin
            @(negedge clk_i);
            lat++;
        end
        check("valid_seen", {31'd0, valid_o}, 32'd1);
        res = data_o;
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                valid_i = 1'b1;
                dataA_i = $urandom;
                dataB_i = $urandom;
            end
            @(negedge clk_i);
            check("hold_data", data_o, res);
            check("hold_ready", {31'd0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;

        // Pin the model with hand-computed quotients
        check("model_6_2",   fp_model(32'h40C00000, 32'h40000000), 32'h40400000);
        check("model_1_3",   fp_model(32'h3F800000, 32'h40400000), 32'h3EAAAAAA);
        check("model_m8_05", fp_model(32'hC1000000, 32'h3F000000), 32'hC1800000);
`ifdef FPDIV_SPECIAL_EN
        check("model_x_0",   fp_model(32'h3F800000, 32'h00000000), 32'h7F800000);
        check("model_0_0",   fp_model(32'h00000000, 32'h00000000), 32'h7FC00000);
        check("model_ovf",   fp_model(32'h7F000000, 32'h00800000), 32'h7F800000);
`else
        check("model_wrap",  fp_model(32'h7F000000, 32'h00800000), 32'h3E000000);
`endif

        // Reset state
        #1 rst_ni = 1'b0;
        #1 check_en = 1'b1;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_data",  data_o, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // First accept right after reset release; valid held for 5 cycles
        run_op(32'h40C00000, 32'h40000000, 5, 1'b0, res, lat);
        check("div_6_2", res, 32'h40400000);
        check("lat_6_2", 32'(lat), 32'd26);

        run_op(32'h3F800000, 32'h40400000, 0, 1'b0, res, lat);
        check("div_1_3", res, 32'h3EAAAAAA);
        check("lat_1_3", 32'(lat), 32'd26);

        // Stall 10 cycles in DONE with ignored valid_i
        run_op(32'hC1000000, 32'h3F000000, 10, 1'b1, res, lat);
        check("div_m8_05", res, 32'hC1800000);
        check("lat_m8_05", 32'(lat), 32'd26);

        // Back-to-back with valid_i held high
        ready_i = 1'b1;
        valid_i = 1'b1;
        dataA_i = 32'h40C00000;
        dataB_i = 32'h40000000;
        @(posedge clk_i);
        @(negedge clk_i);
        dataA_i = 32'h3F800000;
        dataB_i = 32'h40400000;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 64) begin
            @(negedge clk_i);
            lat++;
        end
        check("b2b_first", data_o, 32'h40400000);
        check("b2b_first_lat", 32'(lat), 32'd26);
        @(negedge clk_i);
        check("b2b_idle_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk_i);
        check("b2b_accepted", {31'd0, ready_o}, 32'd0);
        valid_i = 1'b0;
        dataA_i = $urandom;
        dataB_i = $urandom;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 64) begin
            @(negedge clk_i);
            lat++;
        end
        check("b2b_second", data_o, 32'h3EAAAAAA);
        check("b2b_second_lat", 32'(lat), 32'd26);
        @(negedge clk_i);
        ready_i = 1'b0;

        // Reset in the middle of the division
        valid_i = 1'b1;
        dataA_i = 32'h40C00000;
        dataB_i = 32'h40000000;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_ready", {31'd0, ready_o}, 32'd1);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_data",  data_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op(32'h3F800000, 32'h40400000, 1, 1'b0, res, lat);
        check("after_rst_1_3", res, 32'h3EAAAAAA);
        check("after_rst_lat", 32'(lat), 32'd26);

        // Overflow / special boundary
        run_op(32'h7F000000, 32'h00800000, 0, 1'b0, res, lat);
`ifdef FPDIV_SPECIAL_EN
        check("ovf_inf", res, 32'h7F800000);
        run_op(32'h3F800000, 32'h00000000, 0, 1'b0, res, lat);
        check("x_div_0", res, 32'h7F800000);
        run_op(32'h00000000, 32'h00000000, 0, 1'b0, res, lat);
        check("0_div_0", res, 32'h7FC00000);
`else
        check("ovf_wrap", res, 32'h3E000000);
`endif

        // Randomised operations
        for (int k = 0; k < 30; k++) begin
            a = $urandom;
            b = $urandom;
            if (k % 5 == 0) b[30:23] = 8'd0;
            if (k % 7 == 0) a[22:0] = b[22:0];
            run_op(a, b, int'($urandom_range(0, 3)), k[0], res, lat);
            check("rand_result", res, fp_model(a, b));
            check("rand_latency", 32'(lat), 32'd26);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/floatingpoint_divider.md
FLOATINGPOINT_DIVIDER -- requirements
Module: floatingpoint_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, IEEE-754 single-precision word width; only 32 is supported.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1, operands present.
REQ-005 SHALL have port ready_o, output, 1, divider can accept operands.
REQ-006 SHALL have port dataA_i, input, DATA_WIDTH, dividend.
REQ-007 SHALL have port dataB_i, input, DATA_WIDTH, divisor.
REQ-008 SHALL have port valid_o, output, 1, quotient on data_o is valid.
REQ-009 SHALL have port ready_i, input, 1, consumer accepts the quotient.
REQ-010 SHALL have port data_o, output, DATA_WIDTH, quotient {sign, exp[7:0], frac[22:0]}.

Function
REQ-011 SHALL implement the FSM IDLE -> DIV -> NORM -> DONE -> IDLE.
REQ-012 ready_o SHALL be 1 only in IDLE.
REQ-013 Accept occurs on an edge with valid_i & ready_o: latch sign = A[31]^B[31], signed 10-bit exponent EA-EB, remainder = {2'b0,1,A[22:0]}, divisor = {1,B[22:0]}, counter = 24, go to DIV.
REQ-014 Each DIV edge: if rem >= div, set quotient bit = 1 and rem -= div, else quotient bit = 0; then rem <<= 1; shift the bit into the 25-bit quotient q (MSB first); counter decrements; leave DIV after the step with counter = 0 (25 steps).
REQ-015 NORM edge: if q[24]=1, frac = q[23:1] and exp = EA-EB+127; else frac = q[22:0] and exp = EA-EB+126. Register data_o, go to DONE.
REQ-016 Rounding SHALL be truncation; the remainder is discarded.
REQ-017 valid_o SHALL be 1 only in DONE; data_o is stable while valid_o=1.
REQ-018 DONE edge with ready_i=1 SHALL return to IDLE; with ready_i=0 it holds DONE.
REQ-019 Latency is fixed: valid_o rises 26 edges after the accept edge.
REQ-020 Throughput SHALL be at most one operation per 27 cycles; there is no accept-during-DONE overlap.
REQ-021 valid_i while busy SHALL be ignored; operands are latched only at accept, so input changes during DIV have no effect.
REQ-022 data_o SHALL hold the last result after leaving DONE until the next NORM edge.

Reset
REQ-023 rst_ni=0 SHALL immediately force IDLE, ready_o=1, valid_o=0, data_o=0, q=0, rem=0 and counter=0.
REQ-024 Reset mid-DIV or mid-DONE SHALL abort the operation with no valid_o pulse.
REQ-025 The first accept SHALL be possible on the first edge after rst_ni rises.

Configuration
REQ-026 Macro FPDIV_SPECIAL_EN SHALL gate the special-value feature.
REQ-027 With FPDIV_SPECIAL_EN defined, in NORM, in this priority order:
- a NaN operand, 0/0 or inf/inf gives 0x7FC00000;
- x/0 or inf/x gives signed infinity;
- 0/x or x/inf gives signed zero;
- denormal operands are treated as zero;
- computed exp >= 255 saturates to signed infinity;
- computed exp <= 0 flushes to signed zero.
Latency is unchanged.
REQ-028 Without FPDIV_SPECIAL_EN, all operands are treated as normal numbers and exp is the low 8 bits of the computed value (wraps); there is no special-value logic.

Structure
REQ-029 Package fp_pkg SHALL hold:
- FP_EXP_W=8, FP_FRAC_W=23, FP_BIAS=127;
- FP_QNAN=32'h7FC00000;
- the FSM state typedef (IDLE, DIV, NORM, DONE);
- the operand-class typedef (ZERO, NORMAL, INF, NAN).
REQ-030 Sub-module fp_unpack SHALL split a word into sign, exponent and mantissa with hidden bit, plus class; it is instantiated once per operand.

Verification
REQ-031 0x40C00000 / 0x40000000 (6.0/2.0) -> 0x40400000 after exactly 26 edges, valid_o held until ready_i=1.
REQ-032 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated), q[24]=0 path.
REQ-033 0xC1000000 / 0x3F000000 (-8/0.5) -> 0xC1800000; then ready_i=0 for 10 cycles -> data_o stable, ready_o=0, a new valid_i is ignored.
REQ-034 Back-to-back: second valid_i held high -> accepted on the first IDLE edge after the DONE handshake; results arrive in order.
REQ-035 rst_ni pulsed low at DIV step 10 -> ready_o=1 and valid_o=0 immediately; no result; the next operation is correct.
REQ-036 With FPDIV_SPECIAL_EN: 0x3F800000/0x00000000 -> 0x7F800000; 0/0 -> 0x7FC00000; 0x7F000000/0x00800000 -> 0x7F800000.
